cpu_exec_ctrl: RTL and testbench
================================

CPU_EXEC_CTRL -- requirements
Module: cpu_exec_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, 4, program address width; DATA_W, 8, instruction word width; ICNT_W, 8, executed-instruction counter width.
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports listed below, clock and reset first.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 run_req / halt_req / step_req  input  1 each  single-cycle control requests.
REQ-006 ld_valid  input  1  loader beat valid; ld_ready  output  1  loader beat accepted when both high.
REQ-007 ld_addr  input  ADDR_W  write address; ld_data  input  DATA_W  write data.
REQ-008 fetch_addr  input  ADDR_W  CPU program counter; fetch_data  output  DATA_W  instruction at fetch_addr.
REQ-009 cpu_en  output  1  clock enable for all CPU registers (A, B, OUT, PC).
REQ-010 state  output  2  current controller state; icount  output  ICNT_W  executed-instruction count.
REQ-011 With CPU_BREAKPOINT_EN only: bp_en  input  1; bp_addr  input  ADDR_W; bp_hit  output  1.

Function
REQ-012 SHALL hold a 2**ADDR_W x DATA_W program memory in flops; fetch_data = mem[fetch_addr], combinational, in every state.
REQ-013 States: HALT=0, RUN=1, STEP=2, LOAD=3; state output is the registered state.
REQ-014 cpu_en = (state==RUN or state==STEP), gated as in REQ-024; no other source.
REQ-015 ld_ready = 1 in HALT and LOAD, 0 in RUN and STEP.
REQ-016 Accepted beat writes mem[ld_addr] <= ld_data at that edge; same-cycle fetch of that address returns the old word.
REQ-017 HALT priority, one request acted on per cycle: halt_req (stay HALT) > accepted ld beat (-> LOAD) > step_req (-> STEP) > run_req (-> RUN).
REQ-018 LOAD: stays while ld_valid=1 (each cycle a write); -> HALT in the cycle after ld_valid=0; run_req/step_req ignored; halt_req ignored.
REQ-019 STEP lasts exactly one cycle (cpu_en=1 once), then -> HALT unconditionally; requests during STEP ignored.
REQ-020 RUN: halt_req -> HALT next cycle (cpu_en=1 in the halt_req cycle, 0 after); run_req, step_req, ld_valid ignored.
REQ-021 icount increments by 1 on every edge where cpu_en=1; wraps 2**ICNT_W-1 -> 0; no other clearing than reset.

Reset
REQ-022 rst asserted: state=HALT, cpu_en=0, ld_ready=1 after reset release, icount=0, all mem words=0, bp_hit=0; asynchronous, takes effect mid-LOAD/RUN without completing the pending beat or instruction.

Configuration
REQ-023 Macro CPU_BREAKPOINT_EN compiles in the breakpoint; without it bp_en/bp_addr/bp_hit ports and logic are absent and REQ-024/025 do not apply.
REQ-024 With it: in RUN, if bp_en=1, fetch_addr==bp_addr and bp_skip=0, cpu_en is forced 0 that cycle, next state HALT, bp_hit set (sticky).
REQ-025 bp_skip set for the first RUN cycle entered from HALT, so resume executes past the breakpoint; STEP never checks breakpoints; bp_hit cleared when run_req or step_req is acted on.

Structure
REQ-026 Shared package cpu_pkg: state enum (HALT/RUN/STEP/LOAD), ADDR_W/DATA_W default constants, instruction opcode constants.
REQ-027 One sub-module: prog_mem (flop array, one write port, one async read port, async reset to 0).

Verification
REQ-028 Reset, then load mem[0]=0x21, mem[1]=0x90 as back-to-back beats -> state 3 for 2 cycles, then 0; fetch_addr=1 gives 0x90.
REQ-029 HALT, step_req pulse -> exactly one cycle cpu_en=1, state 2 then 0, icount 0->1.
REQ-030 HALT, run_req and step_req same cycle -> STEP taken; then run_req, halt_req after 10 cycles -> cpu_en high 11 cycles, icount +11.
REQ-031 RUN for 260 cycles from icount=0 -> icount=4 (wrap); ld_valid=1 during RUN -> ld_ready=0, memory unchanged.
REQ-032 CPU_BREAKPOINT_EN, bp_en=1, bp_addr=1, PC counting 0,1 -> cpu_en=0 at PC=1, state 0, bp_hit=1; run_req -> PC=1 executes, bp_hit=0.
REQ-033 rst asserted mid-LOAD and mid-RUN -> immediately state 0, cpu_en 0, icount 0, all mem words 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU execution controller: controller states,
// default widths and the instruction opcode map of the attached CPU.
package cpu_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int ICNT_W_DEF = 8;

    // Encoding is visible on the state output, so the values are fixed.
    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_LOAD = 2'd3
    } state_e;

    // Upper nibble of an instruction word is the opcode, lower nibble the operand.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    function automatic logic [3:0] opcode_of(input logic [7:0] instr);
        return instr[7:4];
    endfunction

endpackage

// File: rtl/prog_mem.sv
// Program memory: flop array with one synchronous write port and one
// combinational read port. Every word clears on reset.
module prog_mem
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port; reset wipes the whole array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read is asynchronous; a write to the same address shows up next cycle.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Execution controller for a small CPU: owns the program memory, gates the
// CPU clock enable (HALT/RUN/STEP/LOAD) and counts executed instructions.
// Optional breakpoint logic is compiled in with CPU_BREAKPOINT_EN.
module cpu_exec_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ICNT_W = ICNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              cpu_en,
    output logic [1:0]        state,
`ifdef CPU_BREAKPOINT_EN
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              bp_hit,
`endif
    output logic [ICNT_W-1:0] icount
);

    state_e            state_q, state_d;
    logic [ICNT_W-1:0] icount_q, icount_d;
    logic              ld_acc;
    logic              bp_block;

    assign ld_ready = (state_q == ST_HALT) || (state_q == ST_LOAD);
    assign ld_acc   = ld_valid && ld_ready;

`ifdef CPU_BREAKPOINT_EN
    logic bp_skip_q, bp_skip_d;
    logic bp_hit_q, bp_hit_d;

    // The first RUN cycle after a resume skips the compare so the CPU can
    // execute the instruction it stopped on.
    assign bp_block = (state_q == ST_RUN) && bp_en && (fetch_addr == bp_addr) && !bp_skip_q;

    // Skip flag and sticky hit flag.
    always_comb begin
        bp_skip_d = (state_q == ST_HALT) && (state_d == ST_RUN);
        bp_hit_d  = bp_hit_q;
        if (bp_block) begin
            bp_hit_d = 1'b1;
        end
        if ((state_q == ST_HALT) && ((state_d == ST_RUN) || (state_d == ST_STEP))) begin
            bp_hit_d = 1'b0;
        end
    end

    // Breakpoint registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_skip_q <= 1'b0;
            bp_hit_q  <= 1'b0;
        end else begin
            bp_skip_q <= bp_skip_d;
            bp_hit_q  <= bp_hit_d;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    assign bp_block = 1'b0;
`endif

    // A breakpoint suppresses the enable in the very cycle it matches.
    assign cpu_en = ((state_q == ST_RUN) && !bp_block) || (state_q == ST_STEP);

    // Next-state logic: in HALT only the highest-priority request is honoured.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HALT: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (ld_acc) begin
                    state_d = ST_LOAD;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end else if (run_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req || bp_block) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            ST_LOAD: begin
                if (!ld_valid) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Instruction counter follows the enable and wraps naturally.
    always_comb begin
        icount_d = icount_q;
        if (cpu_en) begin
            icount_d = icount_q + ICNT_W'(1);
        end
    end

    // Controller state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_HALT;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
        end
    end

    assign state  = state_q;
    assign icount = icount_q;

    prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_prog_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ld_acc),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .raddr_i (fetch_addr),
        .rdata_o (fetch_data)
    );

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Bench for cpu_exec_ctrl: directed sequences with literal expectations plus
// a cycle model of the controller checked against the outputs every cycle.
module tb_cpu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [3:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic [3:0] fetch_addr = '0;
    logic [7:0] fetch_data;
    logic       cpu_en;
    logic [1:0] state;
    logic [7:0] icount;
`ifdef CPU_BREAKPOINT_EN
    logic       bp_en = 1'b0;
    logic [3:0] bp_addr = '0;
    logic       bp_hit;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt;

    always #5 clk = ~clk;

    cpu_exec_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .cpu_en     (cpu_en),
        .state      (state),
`ifdef CPU_BREAKPOINT_EN
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .bp_hit     (bp_hit),
`endif
        .icount     (icount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States as plain numbers: 0 halted, 1 running, 2 single step, 3 loading.
    int         m_state;
    int         m_icount;
    logic [7:0] m_mem [16];
    bit         m_skip;
    bit         m_bphit;

    function automatic bit m_block();
`ifdef CPU_BREAKPOINT_EN
        return (m_state == 1) && bp_en && (fetch_addr == bp_addr) && !m_skip;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_en();
        return ((m_state == 1) && !m_block()) || (m_state == 2);
    endfunction

    always @(posedge clk or posedge rst) begin
        int  nxt;
        bit  acc;
        if (rst) begin
            m_state  = 0;
            m_icount = 0;
            m_skip   = 0;
            m_bphit  = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        end else begin
            acc = ld_valid && (m_state == 0 || m_state == 3);
            nxt = m_state;
            case (m_state)
                0: if (halt_req) nxt = 0;
                   else if (acc) nxt = 3;
                   else if (step_req) nxt = 2;
                   else if (run_req) nxt = 1;
                1: if (halt_req || m_block()) nxt = 0;
                2: nxt = 0;
                default: if (!ld_valid) nxt = 0;
            endcase
            if (m_en()) m_icount = (m_icount + 1) % 256;
            if (m_block()) m_bphit = 1;
            if (m_state == 0 && (nxt == 1 || nxt == 2)) m_bphit = 0;
            m_skip = (m_state == 0 && nxt == 1);
            if (acc) m_mem[ld_addr] = ld_data;
            m_state = nxt;
        end
    end

    // Outputs compared just before each rising edge, once inputs have settled.
    always @(negedge clk) begin
        #4;
        if (!rst) begin
            chk("m_state", 32'(state), 32'(m_state));
            chk("m_cpu_en", 32'(cpu_en), 32'(m_en()));
            chk("m_ld_ready", 32'(ld_ready), 32'(m_state == 0 || m_state == 3));
            chk("m_icount", 32'(icount), 32'(m_icount));
            chk("m_fetch", 32'(fetch_data), 32'(m_mem[fetch_addr]));
`ifdef CPU_BREAKPOINT_EN
            chk("m_bp_hit", 32'(bp_hit), 32'(m_bphit));
`endif
        end
    end

    task automatic sweep_zero(input string name);
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 4'(a);
            #1;
            chk(name, 32'(fetch_data), 32'h0);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        @(negedge clk);
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_icount", 32'(icount), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #4 chk("rst_ld_ready", 32'(ld_ready), 32'd1);

        // Two back-to-back loader beats.
        @(negedge clk); ld_valid = 1; ld_addr = 4'd0; ld_data = 8'h21;
        #4 chk("ld0_state", 32'(state), 32'd0);
        @(negedge clk); ld_addr = 4'd1; ld_data = 8'h90;
        #4 chk("ld1_state", 32'(state), 32'd3);
        @(negedge clk); ld_valid = 0;
        #4 chk("ld2_state", 32'(state), 32'd3);
        @(negedge clk); fetch_addr = 4'd1;
        #4 chk("ld_done_state", 32'(state), 32'd0);
        chk("fetch1", 32'(fetch_data), 32'h90);
        @(negedge clk); fetch_addr = 4'd0;
        #4 chk("fetch0", 32'(fetch_data), 32'h21);

        // Single step.
        @(negedge clk); step_req = 1;
        #4 chk("st0_cpu_en", 32'(cpu_en), 32'd0);
        chk("st0_icount", 32'(icount), 32'd0);
        @(negedge clk); step_req = 0;
        #4 chk("st1_state", 32'(state), 32'd2);
        chk("st1_cpu_en", 32'(cpu_en), 32'd1);
        @(negedge clk);
        #4 chk("st2_state", 32'(state), 32'd0);
        chk("st2_cpu_en", 32'(cpu_en), 32'd0);
        chk("st2_icount", 32'(icount), 32'd1);

        // run_req and step_req together: step wins.
        @(negedge clk); run_req = 1; step_req = 1;
        @(negedge clk); run_req = 0; step_req = 0;
        #4 chk("rs_state", 32'(state), 32'd2);
        @(negedge clk);
        #4 chk("rs_after", 32'(state), 32'd0);
        chk("rs_icount", 32'(icount), 32'd2);

        // Run, halt requested in the 11th running cycle.
        @(negedge clk); run_req = 1;
        @(negedge clk); run_req = 0;
        en_cnt = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge clk);
            halt_req = (k == 11);
            #4;
            if (k == 1) chk("run_state", 32'(state), 32'd1);
            if (cpu_en === 1'b1) en_cnt++;
        end
        @(negedge clk); halt_req = 0;
        #4 chk("run_halted", 32'(state), 32'd0);
        chk("run_en_off", 32'(cpu_en), 32'd0);
        chk("run_en_cnt", 32'(en_cnt), 32'd11);
        chk("run_icount", 32'(icount), 32'd13);

        // Counter wrap over 260 running cycles; loader blocked while running.
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        #4 chk("wrap_icount0", 32'(icount), 32'd0);
        @(negedge clk); run_req = 1;
        @(negedge clk); run_req = 0; ld_valid = 1; ld_addr = 4'd5; ld_data = 8'hAA;
        #4 chk("run_ld_ready", 32'(ld_ready), 32'd0);
        for (int k = 2; k <= 260; k++) begin
            @(negedge clk);
            if (k == 260) begin
                halt_req = 1;
                ld_valid = 0;
            end
        end
        @(negedge clk); halt_req = 0; fetch_addr = 4'd5;
        #4 chk("wrap_icount", 32'(icount), 32'd4);
        chk("wrap_state", 32'(state), 32'd0);
        chk("run_mem5", 32'(fetch_data), 32'h0);

        // Reset in the middle of RUN.
        @(negedge clk); ld_valid = 1; ld_addr = 4'd3; ld_data = 8'h55;
        @(negedge clk); ld_valid = 0; fetch_addr = 4'd3;
        @(negedge clk);
        #4 chk("mem3_loaded", 32'(fetch_data), 32'h55);
        @(negedge clk); run_req = 1;
        @(negedge clk); run_req = 0;
        repeat (4) @(negedge clk);
        #2 chk("mr_pre_state", 32'(state), 32'd1);
        rst = 1;
        #1 chk("mr_state", 32'(state), 32'd0);
        chk("mr_cpu_en", 32'(cpu_en), 32'd0);
        chk("mr_icount", 32'(icount), 32'd0);
        sweep_zero("mr_mem");
        @(negedge clk); rst = 0;

        // Reset in the middle of LOAD; the pending beat must not land.
        @(negedge clk); ld_valid = 1; ld_addr = 4'd7; ld_data = 8'h77;
        @(negedge clk); ld_addr = 4'd8; ld_data = 8'h88;
        #1 chk("ml_pre_state", 32'(state), 32'd3);
        #1 rst = 1;
        #1 chk("ml_state", 32'(state), 32'd0);
        chk("ml_ld_ready", 32'(ld_ready), 32'd1);
        ld_valid = 0;
        sweep_zero("ml_mem");
        @(negedge clk); rst = 0;

`ifdef CPU_BREAKPOINT_EN
        // Breakpoint at address 1 with the PC walking 0,1.
        @(negedge clk); bp_en = 1; bp_addr = 4'd1; fetch_addr = 4'd0; run_req = 1;
        @(negedge clk); run_req = 0;
        #4 chk("bp_pc0_en", 32'(cpu_en), 32'd1);
        @(negedge clk); fetch_addr = 4'd1;
        #4 chk("bp_pc1_en", 32'(cpu_en), 32'd0);
        @(negedge clk);
        #4 chk("bp_state", 32'(state), 32'd0);
        chk("bp_hit_set", 32'(bp_hit), 32'd1);
        @(negedge clk); run_req = 1;
        @(negedge clk); run_req = 0;
        #4 chk("bp_resume_en", 32'(cpu_en), 32'd1);
        chk("bp_hit_clr", 32'(bp_hit), 32'd0);
        @(negedge clk); halt_req = 1; fetch_addr = 4'd2;
        @(negedge clk); halt_req = 0; bp_en = 0;
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
